// File: rtl/param_counter.sv
// Parametrised up/down counter with wrap or saturate mode at LIMIT.
// It also provides a one-cycle terminal-event pulse and a sticky overflow flag.
module param_counter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LIMIT       = 255,
    parameter int unsigned RESET_VALUE = 0,
    parameter int unsigned SATURATE    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             at_limit,
    output logic             at_zero,
    output logic             wrap,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] LimitW = LIMIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ResetW = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZeroW  = '0;
    localparam logic [WIDTH-1:0] OneW   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               Sat    = (SATURATE != 0);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    // Priority per edge: clear > load > enable > hold.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (clear) begin
            count_d = ZeroW;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = (load_value > LimitW) ? LimitW : load_value;
        end else if (enable) begin
            if (up_down) begin
                if (count_q == LimitW) begin
                    count_d = Sat ? LimitW : ZeroW;
                    wrap_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q + OneW;
                end
            end else begin
                if (count_q == ZeroW) begin
                    count_d = Sat ? ZeroW : LimitW;
                    wrap_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q - OneW;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= ResetW;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign overflow = ovf_q;
    assign at_limit = (count_q == LimitW);
    assign at_zero  = (count_q == ZeroW);

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
- Parametrised successor to the team's fixed 8-bit free-running counter.
- Adds configurable width and terminal value, up/down direction, synchronous load and clear, count enable, and selectable wrap or saturate mode.
- Adds a terminal-event pulse and a sticky overflow flag.
- Sits behind a thin DUT wrapper; all ports are driven from and observed by the MyHDL bench.

Parameters:
- WIDTH, 8: counter width in bits; legal range 2..32.
- LIMIT, 255: terminal (maximum) count value; must satisfy 1 <= LIMIT <= 2^WIDTH-1.
- RESET_VALUE, 0: value loaded into count on reset; must be <= LIMIT.
- SATURATE, 0: 0 = wrap at the terminal value; 1 = hold at the terminal value.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  count enable; when low, count holds unless clear or load is asserted.
- up_down  input  1  direction: 1 = increment, 0 = decrement.
- clear  input  1  synchronous clear to 0; also clears overflow.
- load  input  1  synchronous load of load_value.
- load_value  input  WIDTH  value to load.
- count  output  WIDTH  current count, registered.
- at_limit  output  1  combinational; high when count == LIMIT.
- at_zero  output  1  combinational; high when count == 0.
- wrap  output  1  registered one-cycle pulse on a terminal event.
- overflow  output  1  registered sticky flag, set on any terminal event.

Behaviour:
- Reset (asynchronous, active-high, may arrive at any time including mid-count):
  - count = RESET_VALUE, wrap = 0, overflow = 0.
  - Takes effect immediately, without waiting for a clock edge.
  - Counting resumes on the first rising edge after reset deasserts.
- Per-edge priority, evaluated at each rising edge: clear > load > enable > hold.
- clear:
  - count <= 0, overflow <= 0, wrap <= 0.
  - Overrides a simultaneous load or enable.
- load:
  - count <= min(load_value, LIMIT); values above LIMIT are clamped to LIMIT.
  - wrap <= 0; overflow is unchanged.
  - A load does not itself generate a terminal event.
- enable with up_down = 1:
  - If count < LIMIT: count <= count + 1, wrap <= 0.
  - If count == LIMIT and SATURATE = 0: count <= 0, wrap <= 1, overflow <= 1.
  - If count == LIMIT and SATURATE = 1: count holds at LIMIT, wrap <= 1, overflow <= 1.
- enable with up_down = 0:
  - If count > 0: count <= count - 1, wrap <= 0.
  - If count == 0 and SATURATE = 0: count <= LIMIT, wrap <= 1, overflow <= 1.
  - If count == 0 and SATURATE = 1: count holds at 0, wrap <= 1, overflow <= 1.
- Hold case (no clear, load or enable): count holds, wrap <= 0.
- Timing:
  - Latency is one cycle from a sampled input to count, wrap and overflow.
  - at_limit and at_zero follow count combinationally, with zero added latency.
- wrap:
  - Is exactly one cycle wide per terminal event.
  - With SATURATE = 1 and enable held at the limit, wrap pulses on every enabled cycle.
- Direction change: up_down may change on any cycle; the new direction takes effect on the next enabled edge. There is no state machine and no dead cycle.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - LIMIT < 2^WIDTH-1 is a legal configuration; the count never exceeds LIMIT.
- Range: count is never observed outside 0..LIMIT after reset.

Test Plan:
- Defaults; reset then enable=1, up_down=1 for 256 cycles.
  -> count runs 0..255 then reads 0; wrap is high for exactly one cycle, coincident with count=0; overflow=1 from then on.
- LIMIT=9, SATURATE=0; count down from reset for 3 cycles.
  -> count 0 -> 9 (wrap pulse) -> 8 -> 7; at_zero=1 only at the first cycle.
- LIMIT=9, SATURATE=1; load 7, then count up for 5 cycles.
  -> count 7, 8, 9, 9, 9; wrap pulses on each of the last two cycles while count holds at 9; at_limit=1.
- Defaults; assert load=1 with load_value=0x80 and clear=1 together, with enable=1.
  -> count=0 and overflow=0 (clear wins).
- LIMIT=9; load_value=15 with load=1.
  -> count=9 (clamped) and wrap=0.
- Mid-count reset:
  - At count=42, assert reset between clock edges.
    -> count=0 and overflow=0 immediately, without waiting for an edge.
  - Deassert reset with enable=1.
    -> count reads 1 after the first subsequent edge.
